cache_line_bridge: RTL and testbench

CACHE_LINE_BRIDGE -- requirements
Module: cache_line_bridge

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_line_assembler.sv | 56 +++++
 rtl/cache_line_bridge.sv | 132 +++++++++++++
 tb/tb_cache_line_bridge.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants and the FSM state type for the cache line bridge.
//   SRAM_ADDR_BIT : cache line address width
//   SRAM_DATA_BIT : cache line width
//   MEM_DATA_BIT  : backing-memory beat width
//   BEATS         : beats per cache line
package cache_pkg;

   localparam int unsigned SRAM_ADDR_BIT = 9;
   localparam int unsigned SRAM_DATA_BIT = 1024;
   localparam int unsigned MEM_DATA_BIT  = 64;
   localparam int unsigned BEATS         = SRAM_DATA_BIT / MEM_DATA_BIT;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StRead,
      StDone
   } state_e;

endpackage

// File: rtl/cache_line_assembler.sv
// Collects in-order read responses into a full cache line.
//   clk_sys_i, rst_sys_i : clock, synchronous active-high reset
//   active_i             : high while the bridge is in the refill state
//   rdata_valid_i/rdata_i: one response beat from backing memory
//   last_o               : the final beat of the line is being taken this cycle
//   data_o               : assembled line, held between refills
module cache_line_assembler #(
   parameter int unsigned SRAM_DATA_BIT = cache_pkg::SRAM_DATA_BIT,
   parameter int unsigned MEM_DATA_BIT  = cache_pkg::MEM_DATA_BIT
) (
   input  logic                     clk_sys_i,
   input  logic                     rst_sys_i,
   input  logic                     active_i,
   input  logic                     rdata_valid_i,
   input  logic [MEM_DATA_BIT-1:0]  rdata_i,
   output logic                     last_o,
   output logic [SRAM_DATA_BIT-1:0] data_o
);

   localparam int unsigned NumBeats = SRAM_DATA_BIT / MEM_DATA_BIT;
   localparam int unsigned CntW     = $clog2(NumBeats);
   localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

   logic [CntW-1:0]          cnt_q, cnt_d;
   logic [SRAM_DATA_BIT-1:0] data_q, data_d;
   logic                     take;

   // Responses outside a refill are dropped; the counter parks at 0 so the
   // next refill always starts filling slice 0.
   assign take = active_i & rdata_valid_i;

   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      if (!active_i) begin
         cnt_d = '0;
      end else if (take) begin
         cnt_d = cnt_q + 1'b1;
         data_d[cnt_q*MEM_DATA_BIT +: MEM_DATA_BIT] = rdata_i;
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         cnt_q  <= '0;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         data_q <= data_d;
      end
   end

   assign last_o = take && (cnt_q == LastBeat);
   assign data_o = data_q;

endmodule

// File: rtl/cache_line_bridge.sv
// Bridges whole-line SRAM requests from Cache_sets onto a beat-wide
// valid/ready memory port: writebacks are split into BEATS write beats,
// refills issue BEATS read beats and reassemble the in-order responses.
//   clk_sys_i, rst_sys_i           : clock, synchronous active-high reset
//   SRAM_ena_i/wea_i/addr_i/data_i : line request (wea=1 writeback)
//   SRAM_data_o                    : last refilled line
//   SRAM_busy_o, SRAM_done_o       : transfer in progress, completion pulse
//   MEM_req_*                      : beat request channel
//   MEM_rdata_valid_i, MEM_rdata_i : in-order read responses
module cache_line_bridge
   import cache_pkg::*;
#(
   parameter int unsigned SRAM_ADDR_BIT = cache_pkg::SRAM_ADDR_BIT,
   parameter int unsigned SRAM_DATA_BIT = cache_pkg::SRAM_DATA_BIT,
   parameter int unsigned MEM_DATA_BIT  = cache_pkg::MEM_DATA_BIT,
   parameter int unsigned MEM_ADDR_BIT  = SRAM_ADDR_BIT + $clog2(SRAM_DATA_BIT / MEM_DATA_BIT)
) (
   input  logic                     clk_sys_i,
   input  logic                     rst_sys_i,
   input  logic                     SRAM_ena_i,
   input  logic                     SRAM_wea_i,
   input  logic [SRAM_ADDR_BIT-1:0] SRAM_addr_i,
   input  logic [SRAM_DATA_BIT-1:0] SRAM_data_i,
   output logic [SRAM_DATA_BIT-1:0] SRAM_data_o,
   output logic                     SRAM_busy_o,
   output logic                     SRAM_done_o,
   output logic                     MEM_req_valid_o,
   input  logic                     MEM_req_ready_i,
   output logic                     MEM_req_wea_o,
   output logic [MEM_ADDR_BIT-1:0]  MEM_req_addr_o,
   output logic [MEM_DATA_BIT-1:0]  MEM_wdata_o,
   input  logic                     MEM_rdata_valid_i,
   input  logic [MEM_DATA_BIT-1:0]  MEM_rdata_i
);

   localparam int unsigned NumBeats = SRAM_DATA_BIT / MEM_DATA_BIT;
   localparam int unsigned CntW     = $clog2(NumBeats);
   localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

   state_e                   state_q, state_d;
   logic [SRAM_ADDR_BIT-1:0] addr_q, addr_d;
   logic [SRAM_DATA_BIT-1:0] line_q, line_d;
   logic [CntW-1:0]          req_cnt_q, req_cnt_d;
   logic                     req_done_q, req_done_d;
   logic                     req_fire;
   logic                     resp_last;

   assign req_fire = MEM_req_valid_o & MEM_req_ready_i;

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      line_d          = line_q;
      req_cnt_d       = req_cnt_q;
      req_done_d      = req_done_q;
      MEM_req_valid_o = 1'b0;
      MEM_req_wea_o   = 1'b0;
      MEM_req_addr_o  = '0;
      MEM_wdata_o     = '0;
      unique case (state_q)
         StIdle: begin
            req_cnt_d  = '0;
            req_done_d = 1'b0;
            if (SRAM_ena_i) begin
               addr_d  = SRAM_addr_i;
               line_d  = SRAM_data_i;
               state_d = SRAM_wea_i ? StWrite : StRead;
            end
         end
         StWrite: begin
            MEM_req_valid_o = 1'b1;
            MEM_req_wea_o   = 1'b1;
            MEM_req_addr_o  = MEM_ADDR_BIT'({addr_q, req_cnt_q});
            MEM_wdata_o     = line_q[req_cnt_q*MEM_DATA_BIT +: MEM_DATA_BIT];
            if (req_fire) begin
               req_cnt_d = req_cnt_q + 1'b1;
               if (req_cnt_q == LastBeat) state_d = StDone;
            end
         end
         StRead: begin
            // Requests may finish well before the responses do; valid drops
            // as soon as the last request is taken.
            MEM_req_valid_o = !req_done_q;
            MEM_req_addr_o  = MEM_ADDR_BIT'({addr_q, req_cnt_q});
            if (req_fire) begin
               req_cnt_d = req_cnt_q + 1'b1;
               if (req_cnt_q == LastBeat) req_done_d = 1'b1;
            end
            if (resp_last) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         line_q     <= '0;
         req_cnt_q  <= '0;
         req_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         line_q     <= line_d;
         req_cnt_q  <= req_cnt_d;
         req_done_q <= req_done_d;
      end
   end

   assign SRAM_busy_o = (state_q != StIdle);
   assign SRAM_done_o = (state_q == StDone);

   cache_line_assembler #(
      .SRAM_DATA_BIT (SRAM_DATA_BIT),
      .MEM_DATA_BIT  (MEM_DATA_BIT)
   ) u_assembler (
      .clk_sys_i     (clk_sys_i),
      .rst_sys_i     (rst_sys_i),
      .active_i      (state_q == StRead),
      .rdata_valid_i (MEM_rdata_valid_i),
      .rdata_i       (MEM_rdata_i),
      .last_o        (resp_last),
      .data_o        (SRAM_data_o)
   );

endmodule

// File: tb/tb_cache_line_bridge.sv
// Directed bench for cache_line_bridge with a latency-2 read responder.
module tb_cache_line_bridge;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic          wea;
   logic [8:0]    saddr;
   logic [1023:0] sdata_in;
   logic [1023:0] sdata_out;
   logic          busy;
   logic          done;
   logic          req_valid;
   logic          req_ready;
   logic          req_wea;
   logic [12:0]   req_addr;
   logic [63:0]   wdata;
   logic          rvalid = 1'b0;
   logic [63:0]   rdata  = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cache_line_bridge u_dut (
      .clk_sys_i         (clk),
      .rst_sys_i         (rst),
      .SRAM_ena_i        (ena),
      .SRAM_wea_i        (wea),
      .SRAM_addr_i       (saddr),
      .SRAM_data_i       (sdata_in),
      .SRAM_data_o       (sdata_out),
      .SRAM_busy_o       (busy),
      .SRAM_done_o       (done),
      .MEM_req_valid_o   (req_valid),
      .MEM_req_ready_i   (req_ready),
      .MEM_req_wea_o     (req_wea),
      .MEM_req_addr_o    (req_addr),
      .MEM_wdata_o       (wdata),
      .MEM_rdata_valid_i (rvalid),
      .MEM_rdata_i       (rdata)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read responder: a read request accepted at edge E is answered with
   // data 64'h1000 + beat index, sampled by the DUT at edge E+2.
   logic        resp_en = 1'b0;
   logic        inj_v   = 1'b0;
   logic [63:0] inj_d   = '0;
   logic        seen_v  = 1'b0;
   logic [63:0] seen_d  = '0;
   logic        pipe_v  = 1'b0;
   logic [63:0] pipe_d  = '0;

   always @(negedge clk) begin
      seen_v = resp_en && req_valid && req_ready && !req_wea && !rst;
      seen_d = 64'h1000 + {60'd0, req_addr[3:0]};
   end

   always @(posedge clk) begin
      #2;
      if (rst) begin
         rvalid = 1'b0;
         pipe_v = 1'b0;
      end else if (inj_v) begin
         rvalid = 1'b1;
         rdata  = inj_d;
      end else begin
         rvalid = pipe_v;
         rdata  = pipe_d;
      end
      pipe_v = seen_v && !rst;
      pipe_d = seen_d;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int beat;
      int cyc;
      int reqs;
      int bad;
      int dones;
      int resp;
      logic prev_done;
      logic d_seen;

      rst = 1'b1; ena = 1'b0; wea = 1'b0; saddr = '0; sdata_in = '0; req_ready = 1'b1;
      tick();
      tick();
      check_eq("rst_busy",  busy, 0);
      check_eq("rst_done",  done, 0);
      check_eq("rst_valid", req_valid, 0);
      check_eq("rst_wea",   req_wea, 0);
      check_eq("rst_addr",  req_addr, 0);
      check_eq("rst_wdata", wdata, 0);
      check_eq("rst_data",  |sdata_out, 0);
      rst = 1'b0;
      tick();

      // Writeback, ready always high: beats T+1..T+16, done at T+17.
      for (int k = 0; k < 16; k++) sdata_in[k*64 +: 64] = 64'hA5A5_0000_0000_0000 + 64'(k);
      saddr = 9'h040; wea = 1'b1; ena = 1'b1;
      tick();
      ena = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check_eq("wb_valid", req_valid, 1);
         check_eq("wb_wea",   req_wea, 1);
         check_eq("wb_addr",  req_addr, 64'h400 + 64'(k));
         check_eq("wb_wdata", wdata, 64'hA5A5_0000_0000_0000 + 64'(k));
         check_eq("wb_done_early", done, 0);
         tick();
      end
      check_eq("wb_done", done, 1);
      check_eq("wb_busy_done", busy, 1);
      tick();
      check_eq("wb_done_clr", done, 0);
      check_eq("wb_busy_clr", busy, 0);

      // Writeback with ready alternating 0/1 from the first beat.
      saddr = 9'h040; wea = 1'b1; ena = 1'b1;
      tick();
      ena = 1'b0;
      req_ready = 1'b0;
      beat = 0;
      cyc  = 0;
      while (!done && cyc < 64) begin
         check_eq("st_valid", req_valid, 1);
         check_eq("st_addr",  req_addr, 64'h400 + 64'(beat));
         check_eq("st_wdata", wdata, 64'hA5A5_0000_0000_0000 + 64'(beat));
         if (req_ready) beat++;
         cyc++;
         tick();
         req_ready = ~req_ready;
      end
      check_eq("st_beats",  beat, 16);
      check_eq("st_cycles", cyc, 32);
      check_eq("st_done",   done, 1);
      req_ready = 1'b1;
      tick();

      // Refill of 9'h040 with an ignored request for 9'h041 while busy.
      resp_en = 1'b1;
      saddr = 9'h040; wea = 1'b0; ena = 1'b1;
      tick();
      ena = 1'b0;
      reqs = 0; bad = 0; dones = 0; prev_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c == 3) begin
            ena = 1'b1; saddr = 9'h041;
         end else begin
            ena = 1'b0;
         end
         if (req_valid && req_ready) begin
            reqs++;
            if (req_addr[12:4] != 9'h040) bad++;
         end
         if (prev_done) check_eq("rf_busy_clr", busy, 0);
         prev_done = done;
         if (done) dones++;
         tick();
      end
      check_eq("rf_reqs",  reqs, 16);
      check_eq("rf_bad",   bad, 0);
      check_eq("rf_dones", dones, 1);
      check_eq("rf_idle",  busy, 0);
      for (int k = 0; k < 16; k++) check_eq("rf_data", sdata_out[k*64 +: 64], 64'h1000 + 64'(k));

      // Stray response in IDLE must be ignored.
      inj_d = 64'hDEAD; inj_v = 1'b1;
      tick();
      d_seen = done;
      inj_v = 1'b0;
      tick();
      d_seen = d_seen | done;
      tick();
      d_seen = d_seen | done;
      check_eq("stray_done",  d_seen, 0);
      check_eq("stray_busy",  busy, 0);
      check_eq("stray_data0", sdata_out[63:0], 64'h1000);
      check_eq("stray_data1", sdata_out[127:64], 64'h1001);

      // Reset after 5 refill responses, then a fresh refill of 9'h010.
      saddr = 9'h040; wea = 1'b0; ena = 1'b1;
      tick();
      ena = 1'b0;
      resp = 0;
      cyc  = 0;
      while (resp < 5 && cyc < 40) begin
         tick();
         cyc++;
         if (rvalid) resp++;
      end
      check_eq("ab_resp", resp, 5);
      rst = 1'b1;
      tick();
      check_eq("ab_busy",  busy, 0);
      check_eq("ab_valid", req_valid, 0);
      check_eq("ab_done",  done, 0);
      check_eq("ab_data",  |sdata_out, 0);
      rst = 1'b0;
      saddr = 9'h010; wea = 1'b0; ena = 1'b1;
      tick();
      ena = 1'b0;
      check_eq("re_valid", req_valid, 1);
      check_eq("re_addr",  req_addr, 64'h100);
      cyc = 0;
      while (!done && cyc < 60) begin
         tick();
         cyc++;
      end
      check_eq("re_done",   done, 1);
      check_eq("re_data0",  sdata_out[63:0], 64'h1000);
      check_eq("re_data15", sdata_out[1023:960], 64'h100F);
      tick();
      check_eq("re_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
